// File: rtl/impl_ram_pkg.sv
// impl_ram_pkg: shared master index, request struct and address range check for the RAM port arbiter
package impl_ram_pkg;
  typedef enum logic {MST_CORE = 1'b0, MST_LOADER = 1'b1} mst_e;
  typedef enum logic {LK_IDLE = 1'b0, LK_LOCKED = 1'b1} lock_e;
  localparam int unsigned AW_MAX = 64;
  typedef struct packed {
    logic [AW_MAX-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } req_t;
  function automatic logic is_oob(input logic [AW_MAX-1:0] addr, input int unsigned maxblk);
    return (addr >> (maxblk + 2)) != '0;
  endfunction
endpackage

// File: rtl/impl_rr_arb2.sv
// impl_rr_arb2: two-way round-robin arbiter with loader-lock override and accept gating
module impl_rr_arb2
  import impl_ram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       lock_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output mst_e       win_o
);
  mst_e ptr_q, ptr_d;
  logic any;
  always_comb begin
    win_o = lock_i ? MST_LOADER : (&req_i) ? ptr_q : req_i[1] ? MST_LOADER : MST_CORE;
    any   = accept_i & (lock_i ? req_i[1] : |req_i);
    gnt_o = any ? (win_o == MST_LOADER ? 2'b10 : 2'b01) : 2'b00;
    ptr_d = any ? (win_o == MST_LOADER ? MST_CORE : MST_LOADER) : ptr_q;
  end
  always_ff @(posedge clk_i) ptr_q <= rst_i ? MST_CORE : ptr_d;
endmodule

// File: rtl/impl_ram_port_arbiter.sv
// impl_ram_port_arbiter: shares RAM port B between core LSU (M0) and loader/DMA (M1) with lock, range check and 1-cycle response
module impl_ram_port_arbiter
  import impl_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned MAXBLKSIZE = 17,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  m1_err_o,
  input  logic                  m1_lock_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);
  if (RD_LATENCY != 1) begin : g_bad_latency
    $error("impl_ram_port_arbiter supports RD_LATENCY=1 only");
  end
  lock_e lock_q, lock_d;
  mst_e win, owner_q;
  req_t r0, r1, rw;
  logic [1:0] gnt;
  logic lock_act, any, oob, valid_q, err_q, rd_q, rv;
  assign r0 = '{addr: AW_MAX'(m0_addr_i), we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign r1 = '{addr: AW_MAX'(m1_addr_i), we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
  always_ff @(posedge clk_i) lock_q <= rst_i ? LK_IDLE : lock_d;
  always_comb begin
    lock_d = lock_q == LK_LOCKED ? (m1_lock_i ? LK_LOCKED : LK_IDLE)
                                 : (gnt[1] & m1_lock_i ? LK_LOCKED : LK_IDLE);
  end
  always_comb lock_act = (lock_q == LK_LOCKED) & m1_lock_i;
  impl_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({m1_req_i, m0_req_i}),
    .lock_i   (lock_act),
    .accept_i (~rst_i),
    .gnt_o    (gnt),
    .win_o    (win)
  );
  always_comb begin
    rw          = win == MST_LOADER ? r1 : r0;
    oob         = is_oob(rw.addr, MAXBLKSIZE);
    any         = |gnt;
    m0_gnt_o    = gnt[0];
    m1_gnt_o    = gnt[1];
    ram_en_o    = any & ~oob;
    ram_we_o    = ram_en_o & rw.we;
    ram_addr_o  = rw.addr[ADDR_WIDTH-1:0];
    ram_be_o    = rw.be;
    ram_wdata_o = rw.wdata;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      owner_q <= MST_CORE;
    end else begin
      valid_q <= any;
      err_q   <= oob;
      rd_q    <= ~rw.we;
      owner_q <= win;
    end
  end
  always_comb begin
    rv          = valid_q & ~rst_i;
    m0_rvalid_o = rv & (owner_q == MST_CORE);
    m1_rvalid_o = rv & (owner_q == MST_LOADER);
    m0_err_o    = m0_rvalid_o & err_q;
    m1_err_o    = m1_rvalid_o & err_q;
    m0_rdata_o  = m0_rvalid_o & ~err_q & rd_q ? ram_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o & ~err_q & rd_q ? ram_rdata_i : '0;
  end
endmodule

// File: tb/tb_impl_ram_port_arbiter.sv
// tb_impl_ram_port_arbiter: directed and random checks of the RAM port arbiter against a transaction-level model
module tb_impl_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst_i;
  logic m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_err_o;
  logic [21:0] m0_addr_i;
  logic [3:0] m0_be_i;
  logic [31:0] m0_wdata_i, m0_rdata_o;
  logic m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o, m1_lock_i;
  logic [21:0] m1_addr_i;
  logic [3:0] m1_be_i;
  logic [31:0] m1_wdata_i, m1_rdata_o;
  logic ram_en_o, ram_we_o;
  logic [21:0] ram_addr_o;
  logic [3:0] ram_be_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;
  logic [31:0] ram_mem [0:255];
  logic [31:0] ref_mem [0:255];
  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int mdl_ptr = 0;
  int pend_o = 0;
  bit mdl_locked = 1'b0;
  bit pend_v = 1'b0;
  bit pend_e = 1'b0;
  logic [31:0] pend_d = '0;
  always #5 clk = ~clk;
  impl_ram_port_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .m0_req_i    (m0_req_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_addr_i   (m0_addr_i),
    .m0_we_i     (m0_we_i),
    .m0_be_i     (m0_be_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m0_err_o    (m0_err_o),
    .m1_req_i    (m1_req_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_addr_i   (m1_addr_i),
    .m1_we_i     (m1_we_i),
    .m1_be_i     (m1_be_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .m1_err_o    (m1_err_o),
    .m1_lock_i   (m1_lock_i),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    m = old;
    for (int k = 0; k < 4; k++) if (be[k]) m[8*k+:8] = wd[8*k+:8];
    return m;
  endfunction
  // write-first block RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_mem[ram_addr_o[9:2]] <= ram_we_o ? merge(ram_mem[ram_addr_o[9:2]], ram_wdata_o, ram_be_o) : ram_mem[ram_addr_o[9:2]];
      ram_rdata_i <= ram_we_o ? merge(ram_mem[ram_addr_o[9:2]], ram_wdata_o, ram_be_o) : ram_mem[ram_addr_o[9:2]];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic rst,
                       input logic q0, input logic w0, input logic [3:0] b0, input logic [21:0] a0, input logic [31:0] d0,
                       input logic q1, input logic w1, input logic [3:0] b1, input logic [21:0] a1, input logic [31:0] d1,
                       input logic lk);
    int w;
    logic [21:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    logic wr, oob, rv;
    int idx;
    rst_i = rst;
    m0_req_i = q0; m0_we_i = w0; m0_be_i = b0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_req_i = q1; m1_we_i = w1; m1_be_i = b1; m1_addr_i = a1; m1_wdata_i = d1;
    m1_lock_i = lk;
    @(negedge clk);
    if (rst) w = -1;
    else if (mdl_locked && lk) w = q1 ? 1 : -1;
    else if (q0 && q1) w = mdl_ptr;
    else if (q0) w = 0;
    else if (q1) w = 1;
    else w = -1;
    a = (w == 1) ? a1 : a0;
    wr = (w == 1) ? w1 : w0;
    be = (w == 1) ? b1 : b0;
    wd = (w == 1) ? d1 : d0;
    oob = a >= 22'h080000;
    check("m0_gnt", 64'(m0_gnt_o), 64'(w == 0));
    check("m1_gnt", 64'(m1_gnt_o), 64'(w == 1));
    check("ram_en", 64'(ram_en_o), 64'(w >= 0 && !oob));
    if (w >= 0 && !oob) begin
      check("ram_addr", 64'(ram_addr_o), 64'(a));
      check("ram_we", 64'(ram_we_o), 64'(wr));
      if (wr) begin
        check("ram_be", 64'(ram_be_o), 64'(be));
        check("ram_wdata", 64'(ram_wdata_o), 64'(wd));
      end
    end else check("ram_we_idle", 64'(ram_we_o), 64'd0);
    rv = pend_v && !rst;
    check("m0_rvalid", 64'(m0_rvalid_o), 64'(rv && pend_o == 0));
    check("m1_rvalid", 64'(m1_rvalid_o), 64'(rv && pend_o == 1));
    check("m0_rdata", 64'(m0_rdata_o), 64'((rv && pend_o == 0) ? pend_d : 32'd0));
    check("m1_rdata", 64'(m1_rdata_o), 64'((rv && pend_o == 1) ? pend_d : 32'd0));
    if (rv && pend_o == 0) check("m0_err", 64'(m0_err_o), 64'(pend_e));
    if (rv && pend_o == 1) check("m1_err", 64'(m1_err_o), 64'(pend_e));
    if (ram_en_o) en_cnt++;
    if (rst) begin
      mdl_ptr = 0;
      mdl_locked = 1'b0;
      pend_v = 1'b0;
    end else begin
      mdl_locked = mdl_locked ? bit'(lk) : bit'(w == 1 && lk);
      pend_v = w >= 0;
      if (w >= 0) begin
        mdl_ptr = 1 - w;
        pend_o = w;
        pend_e = oob;
        pend_d = '0;
        if (!oob) begin
          idx = int'(a[9:2]);
          if (wr) begin
            ref_mem[idx] = merge(ref_mem[idx], wd, be);
          end else begin
            pend_d = ref_mem[idx];
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic rst);
    drive(rst, 0, 0, 4'h0, 22'h0, 32'h0, 0, 0, 4'h0, 22'h0, 32'h0, 0);
  endtask
  initial begin
    logic [31:0] old;
    logic [21:0] ra0, ra1;
    logic lk;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[8'h40] = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;
    idle(1);
    idle(1);
    drive(0, 1, 0, 4'hF, 22'h000100, 32'h0, 0, 0, 4'h0, 22'h0, 32'h0, 0);
    check("plan_read_rdata", 64'(m0_rdata_o), 64'(32'hDEADBEEF));
    idle(0);
    idle(1);
    en_cnt = 0;
    for (int i = 0; i < 4; i++)
      drive(0, 1, 0, 4'hF, 22'(i * 4), 32'h0, 1, 0, 4'hF, 22'(64 + i * 4), 32'h0, 0);
    check("plan_rr_en_count", 64'(en_cnt), 64'd4);
    idle(0);
    idle(1);
    drive(0, 1, 0, 4'hF, 22'h10, 32'h0, 0, 0, 4'h0, 22'h0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 4'hF, 22'h20, 32'h0, 1, 1, 4'hF, 22'(i * 4), 32'h1000 + 32'(i), 1);
    drive(0, 1, 0, 4'hF, 22'h20, 32'h0, 1, 0, 4'hF, 22'h30, 32'h0, 0);
    idle(0);
    drive(0, 1, 0, 4'hF, 22'h080000, 32'h0, 0, 0, 4'h0, 22'h0, 32'h0, 0);
    check("plan_oob_err", 64'(m0_err_o), 64'd1);
    idle(0);
    old = ref_mem[8'h80];
    drive(0, 0, 0, 4'h0, 22'h0, 32'h0, 1, 1, 4'b0011, 22'h000200, 32'hCAFEF00D, 0);
    drive(0, 1, 0, 4'hF, 22'h000200, 32'h0, 0, 0, 4'h0, 22'h0, 32'h0, 0);
    check("plan_wr_rd_merge", 64'(m0_rdata_o), 64'({old[31:16], 16'hF00D}));
    idle(0);
    drive(0, 1, 0, 4'hF, 22'h40, 32'h0, 0, 0, 4'h0, 22'h0, 32'h0, 0);
    drive(1, 1, 0, 4'hF, 22'h40, 32'h0, 1, 0, 4'hF, 22'h44, 32'h0, 0);
    idle(0);
    drive(0, 0, 0, 4'h0, 22'h0, 32'h0, 1, 1, 4'hF, 22'h48, 32'h55AA55AA, 1);
    drive(1, 1, 0, 4'hF, 22'h4C, 32'h0, 1, 0, 4'hF, 22'h48, 32'h0, 1);
    drive(0, 1, 0, 4'hF, 22'h4C, 32'h0, 1, 0, 4'hF, 22'h48, 32'h0, 1);
    idle(0);
    lk = 1'b0;
    for (int n = 0; n < 500; n++) begin
      ra0 = ($urandom_range(0, 9) == 0) ? (22'($urandom) | 22'h080000) : 22'($urandom_range(0, 255) << 2);
      ra1 = ($urandom_range(0, 9) == 0) ? (22'($urandom) | 22'h080000) : 22'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 3) == 0) lk = ~lk;
      drive(logic'($urandom_range(0, 49) == 0),
            logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)), 4'($urandom), ra0, $urandom,
            logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)), 4'($urandom), ra1, $urandom,
            lk);
    end
    idle(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
